// File: rtl/mycpu_defs.sv
// rtl/mycpu_defs.sv - shared fetch-stage constants and PC FSM state encoding
package mycpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_e;

endpackage

// File: rtl/redirect_arb.sv
// rtl/redirect_arb.sv - fixed-priority redirect select: exc > eret > taken branch > jump
module redirect_arb
    import mycpu_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic        req,
    output logic        req_hi,
    output logic [31:0] target
);

    // req_hi marks the exc/eret class that may overwrite an already-latched redirect
    assign req_hi = exc_valid || eret_valid;
    assign req    = req_hi || (branch_valid && branch_taken) || jump_valid;

    always_comb begin
        target = 32'h0000_0000;
        if (exc_valid)
            target = EXC_VECTOR;
        else if (eret_valid)
            target = epc;
        else if (branch_valid && branch_taken)
            target = branch_target;
        else if (jump_valid)
            target = jump_target;
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register, stall hold and pending-redirect FSM
module pc_redirect_unit
    import mycpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_f,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus8,
    output logic        inst_sram_en,
    output logic        redirect,
    output logic        addr_err_f
);

    pc_state_e   state;
    logic [31:0] pend_target;
    logic        req;
    logic        req_hi;
    logic [31:0] target;

    redirect_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .exc_valid     (exc_valid),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .req           (req),
        .req_hi        (req_hi),
        .target        (target)
    );

    assign pc_plus8   = pc_f + 32'd8;
    assign addr_err_f = (pc_f[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_BOOT;
            pc_f         <= RESET_PC;
            pend_target  <= 32'h0000_0000;
            inst_sram_en <= 1'b0;
            redirect     <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state        <= ST_RUN;
                    inst_sram_en <= 1'b1;
                    redirect     <= 1'b0;
                end
                ST_RUN: begin
                    if (!stall_f) begin
                        pc_f     <= req ? target : pc_f + 32'd4;
                        redirect <= req;
                    end else begin
                        redirect <= 1'b0;
                        if (req) begin
                            pend_target <= target;
                            state       <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (stall_f) begin
                        redirect <= 1'b0;
                        // older branch/jump keeps its slot; only exc/eret may replace it
                        if (req_hi)
                            pend_target <= target;
                    end else begin
                        pc_f     <= req_hi ? target : pend_target;
                        redirect <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    redirect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed-vector scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall_f;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] pc_plus8;
    logic        inst_sram_en;
    logic        redirect;
    logic        addr_err_f;

    typedef struct packed {
        logic [31:0] pc;
        logic        red;
        logic        en;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_redirect_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall_f       (stall_f),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .exc_valid     (exc_valid),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .pc_f          (pc_f),
        .pc_plus8      (pc_plus8),
        .inst_sram_en  (inst_sram_en),
        .redirect      (redirect),
        .addr_err_f    (addr_err_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        stall_f       = 1'b0;
        branch_valid  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;
        exc_valid     = 1'b0;
        eret_valid    = 1'b0;
        epc           = 32'h0;
    endtask

    // expectation describes outputs just after the coming rising edge
    task automatic tick(input logic [31:0] pc, input logic red, input logic en = 1'b1);
        exp_t e;
        e.pc  = pc;
        e.red = red;
        e.en  = en;
        sb.push_back(e);
        @(negedge clk);
        clr();
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] pexp;
        logic [31:0] p8;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                pexp = e.pc;
                p8   = pexp + 32'd8;
                chk("pc_f", pc_f, pexp);
                chk("redirect", {31'b0, redirect}, {31'b0, e.red});
                chk("inst_sram_en", {31'b0, inst_sram_en}, {31'b0, e.en});
                chk("pc_plus8", pc_plus8, p8);
                chk("addr_err_f", {31'b0, addr_err_f}, {31'b0, (pexp[1:0] != 2'b00)});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        resetn = 1'b0;
        clr();
        @(negedge clk);
        tick(32'hBFC0_0000, 0, 0);
        // release: BOOT edge, then sequential fetch
        resetn = 1'b1;
        tick(32'hBFC0_0000, 0, 1);
        tick(32'hBFC0_0004, 0);
        tick(32'hBFC0_0008, 0);
        tick(32'hBFC0_000C, 0);
        tick(32'hBFC0_0010, 0);
        // taken branch at pc 0x10
        branch_valid = 1; branch_taken = 1; branch_target = 32'hBFC0_0100;
        tick(32'hBFC0_0100, 1);
        tick(32'hBFC0_0104, 0);
        jump_valid = 1; jump_target = 32'hBFC0_0010;
        tick(32'hBFC0_0010, 1);
        branch_valid = 1; branch_taken = 0; branch_target = 32'hBFC0_0100;
        tick(32'hBFC0_0014, 0);
        // stalled jump, three stall cycles
        stall_f = 1; jump_valid = 1; jump_target = 32'hBFC0_0200;
        tick(32'hBFC0_0014, 0);
        stall_f = 1;
        tick(32'hBFC0_0014, 0);
        stall_f = 1;
        tick(32'hBFC0_0014, 0);
        tick(32'hBFC0_0200, 1);
        tick(32'hBFC0_0204, 0);
        stall_f = 1;
        tick(32'hBFC0_0204, 0);
        tick(32'hBFC0_0208, 0);
        // priority: exc beats branch and jump
        exc_valid = 1; branch_valid = 1; branch_taken = 1; branch_target = 32'h1000;
        jump_valid = 1; jump_target = 32'h2000;
        tick(32'hBFC0_0380, 1);
        tick(32'hBFC0_0384, 0);
        // pending branch overwritten by exc
        stall_f = 1; branch_valid = 1; branch_taken = 1; branch_target = 32'h1000;
        tick(32'hBFC0_0384, 0);
        stall_f = 1; exc_valid = 1;
        tick(32'hBFC0_0384, 0);
        tick(32'hBFC0_0380, 1);
        tick(32'hBFC0_0384, 0);
        // pending jump keeps its slot against a later branch
        stall_f = 1; jump_valid = 1; jump_target = 32'h3000;
        tick(32'hBFC0_0384, 0);
        stall_f = 1; branch_valid = 1; branch_taken = 1; branch_target = 32'h4000;
        tick(32'hBFC0_0384, 0);
        tick(32'h0000_3000, 1);
        // eret beats branch; eret on release replaces pending jump
        eret_valid = 1; epc = 32'hBFC0_0500; branch_valid = 1; branch_taken = 1; branch_target = 32'h5000;
        tick(32'hBFC0_0500, 1);
        stall_f = 1; jump_valid = 1; jump_target = 32'h3000;
        tick(32'hBFC0_0500, 0);
        eret_valid = 1; epc = 32'hBFC0_0600;
        tick(32'hBFC0_0600, 1);
        // wrap and misalignment
        jump_valid = 1; jump_target = 32'hFFFF_FFFC;
        tick(32'hFFFF_FFFC, 1);
        tick(32'h0000_0000, 0);
        tick(32'h0000_0004, 0);
        jump_valid = 1; jump_target = 32'hBFC0_0102;
        tick(32'hBFC0_0102, 1);
        tick(32'hBFC0_0106, 0);
        // reset while a redirect is pending
        stall_f = 1; jump_valid = 1; jump_target = 32'h7000;
        tick(32'hBFC0_0106, 0);
        stall_f = 1; resetn = 1'b0;
        tick(32'hBFC0_0000, 0, 0);
        resetn = 1'b1;
        tick(32'hBFC0_0000, 0, 1);
        tick(32'hBFC0_0004, 0);
        tick(32'hBFC0_0008, 0);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-stage program-counter owner, sitting directly downstream of the branch comparator: it consumes the taken/not-taken bit and target produced in the branch-resolving stage, plus jump, exception and ERET redirects, and drives the instruction-SRAM fetch address. It holds the PC across fetch stalls, latches any redirect that arrives while fetch is stalled, and emits a one-cycle redirect pulse for the hazard unit's squash logic.

## Interface
- RESET_PC, 32'hBFC0_0000: fetch address after reset
- EXC_VECTOR, 32'hBFC0_0380: exception entry address
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- stall_f  in  1  hold PC this cycle
- branch_valid  in  1  conditional branch present in resolving stage
- branch_taken  in  1  comparator result; ignored unless branch_valid
- branch_target  in  32  branch destination
- jump_valid  in  1  j/jal/jr/jalr resolved
- jump_target  in  32  jump destination
- exc_valid  in  1  exception committed
- eret_valid  in  1  ERET committed
- epc  in  32  ERET return address
- pc_f  out  32  current fetch address (registered)
- pc_plus8  out  32  pc_f + 8, link-address helper
- inst_sram_en  out  1  fetch request enable
- redirect  out  1  registered pulse: pc_f was just loaded from a redirect
- addr_err_f  out  1  pc_f[1:0] != 2'b00

## Operation
- States: BOOT, RUN, PEND. Reset: state BOOT, pc_f=RESET_PC, inst_sram_en=0, redirect=0, pending target=0.
- BOOT: one cycle, no fetch; then RUN, inst_sram_en=1 from then on; pc_f unchanged.
- Request selection, priority: exc_valid (EXC_VECTOR) > eret_valid (epc) > branch_valid&&branch_taken (branch_target) > jump_valid (jump_target). Not-taken branch = no request.
- RUN, stall_f=0: request → pc_f<=target, redirect<=1; else pc_f<=pc_f+4, redirect<=0.
- RUN, stall_f=1: pc_f held; request → latch target, go PEND; redirect<=0.
- PEND, stall_f=1: hold; exc/eret overwrite latched target; branch/jump ignored (older redirect wins).
- PEND, stall_f=0: pc_f<=latched target (or exc/eret target if arriving same cycle), redirect<=1, go RUN.
- Addition modulo 2^32: 32'hFFFF_FFFC+4 = 0. Targets loaded unchecked; misalignment only flagged via addr_err_f, PC still advances.
- Delay slot is not squashed here: redirect is advisory; hazard unit decides squash scope.

## Timing
- Request in cycle N, no stall: pc_f=target and redirect=1 in N+1; redirect low in N+2 unless a new request.
- Stall held cycles N..M, request in N: pc_f=target in M+2 (first unstalled edge is end of M+1), redirect=1 same cycle.
- pc_plus8, addr_err_f combinational from pc_f; all other outputs registered.
- resetn low at any time (including PEND) returns to reset values immediately; pending target discarded.
- inst_sram_en drops to 0 only in reset/BOOT; stall does not deassert it.

## Structure
- Shared package mycpu_defs: RESET_PC/EXC_VECTOR defaults, state encoding (BOOT=2'd0, RUN=2'd1, PEND=2'd2).
- One sub-module natural: redirect_arb (combinational priority select → req, target); FSM and PC register in top.

## Test plan
- Reset release: resetn 0→1 → one cycle inst_sram_en=0, then pc_f 32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008 on successive cycles.
- Taken branch: branch_valid=1, branch_taken=1, target 32'hBFC0_0100 at pc_f=32'hBFC0_0010 → next pc_f=32'hBFC0_0100, redirect one cycle; with branch_taken=0 → pc_f=32'hBFC0_0014, redirect=0.
- Stalled redirect: stall_f=1 for 3 cycles, jump_target 32'hBFC0_0200 on first → pc_f frozen, then 32'hBFC0_0200 after release, single redirect pulse.
- Priority: exc_valid, branch taken (32'h1000), jump same cycle → pc_f=32'hBFC0_0380; in PEND with branch pending, exc arrives → exception vector wins.
- Wrap/align: pc_f=32'hFFFF_FFFC → 0; jump_target 32'hBFC0_0102 → addr_err_f=1, next 32'hBFC0_0106.
- Reset mid-PEND: resetn low while pending → pc_f=RESET_PC, redirect=0, no later stale redirect.
